msu_dbuf_regs: RTL and testbench

- Second-generation MSU-1 register and data-streaming block.
- Decodes the 8 SNES-side MSU registers.
- Streams the data port from a parametrised, double-half ring buffer filled by the MCU.
- Runs a refill request/acknowledge handshake per half-buffer so the MCU refills ahead of the SNES read pointer.
- Sits between the SNES bus decoder (register strobes) and the MCU SPI command path (pgm writes, status set/reset, pointer loads).

---
 rtl/msu_dbuf_regs.sv | 216 +++++++++++++++++++++
 tb/tb_msu_dbuf_regs.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_dbuf_regs.sv
// MSU-1 register block with a double-half streaming data buffer.
// The MCU refills each half on request while the SNES reads from the other half.
module msu_dbuf_regs #(
   parameter int         ADDR_W = 11,
   parameter logic [1:0] REV    = 2'd2
) (
   input  logic              clkin,
   input  logic              rst,
   input  logic              enable,
   input  logic [2:0]        reg_addr,
   input  logic [7:0]        reg_data_in,
   output logic [7:0]        reg_data_out,
   input  logic              reg_oe_falling,
   input  logic              reg_oe_rising,
   input  logic              reg_we_rising,
   input  logic              pgm_we,
   input  logic [ADDR_W-1:0] pgm_address,
   input  logic [7:0]        pgm_data,
   output logic [31:0]       addr_out,
   output logic [15:0]       track_out,
   output logic [7:0]        volume_out,
   output logic              volume_latch_out,
   output logic [7:0]        status_out,
   input  logic [5:0]        status_set_bits,
   input  logic [5:0]        status_reset_bits,
   input  logic              status_reset_we,
   input  logic [ADDR_W-1:0] data_ptr_ext,
   input  logic              data_ptr_ext_write,
   output logic              refill_req,
   output logic              refill_half,
   input  logic              refill_ack
);

   logic [7:0]        mem [2**ADDR_W];
   logic [7:0]        rd_data;
   logic [7:0]        rd_mux;
   logic [2:0]        st_sync, ptr_sync, ack_sync;
   logic              st_edge, ptr_edge, ack_edge;
   logic [ADDR_W-1:0] rd_ptr;
   logic [1:0]        half_valid;
   logic              underrun;
   logic              pend_v, pend_half;
   logic              data_busy, audio_busy, audio_error;
   logic [1:0]        audio_status;
   logic [1:0]        audio_ctrl;
   logic              ctrl_start, audio_start, data_start;
   logic              st_pend;
   logic [5:0]        pend_set, pend_rst, set_m, rst_m, st_next;
   logic              rd_strobe, adv, wr, wr_seek;
   logic              cur_half, last_byte;

   assign rd_strobe = reg_oe_falling & enable;
   assign adv       = reg_oe_rising & enable & (reg_addr == 3'd1);
   assign wr        = reg_we_rising & enable;
   assign wr_seek   = wr & (reg_addr == 3'd3);
   assign cur_half  = rd_ptr[ADDR_W-1];
   assign last_byte = &rd_ptr[ADDR_W-2:0];

   // NOTE: the buffer has no reset branch so it maps onto block RAM; contents after reset are don't-care.
   always_ff @(posedge clkin) begin
      if (pgm_we) mem[pgm_address] <= pgm_data;
      rd_data <= mem[rd_ptr];
   end

   // MCU-side strobes are levels from another timing domain: synchronise, then act on the rising edge.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         st_sync  <= '0;
         ptr_sync <= '0;
         ack_sync <= '0;
      end else begin
         st_sync  <= {st_sync[1:0], status_reset_we};
         ptr_sync <= {ptr_sync[1:0], data_ptr_ext_write};
         ack_sync <= {ack_sync[1:0], refill_ack};
      end
   end

   assign st_edge  = st_sync[1]  & ~st_sync[2];
   assign ptr_edge = ptr_sync[1] & ~ptr_sync[2];
   assign ack_edge = ack_sync[1] & ~ack_sync[2];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rd_mux = 8'h00;
      case (reg_addr)
         3'd0: rd_mux = {data_busy, audio_busy, audio_status, audio_error, underrun, REV};
         3'd1: rd_mux = rd_data;
         3'd2: rd_mux = 8'h53;
         3'd3: rd_mux = 8'h2D;
         3'd4: rd_mux = 8'h4D;
         3'd5: rd_mux = 8'h53;
         3'd6: rd_mux = 8'h55;
         3'd7: rd_mux = 8'h31;
      endcase
   end

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) reg_data_out <= 8'h00;
      else if (rd_strobe) reg_data_out <= rd_mux;
   end

   // Read pointer and refill handshake; one request may queue behind the one in flight.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         rd_ptr      <= '0;
         half_valid  <= 2'b00;
         underrun    <= 1'b0;
         refill_req  <= 1'b0;
         refill_half <= 1'b0;
         pend_v      <= 1'b0;
         pend_half   <= 1'b0;
      end else if (ptr_edge) begin
         rd_ptr     <= data_ptr_ext;
         half_valid <= 2'b11;
         underrun   <= 1'b0;
         refill_req <= 1'b0;
         pend_v     <= 1'b0;
      end else if (wr_seek) begin
         half_valid <= 2'b00;
         refill_req <= 1'b0;
         pend_v     <= 1'b0;
      end else begin
         if (ack_edge && refill_req) begin
            refill_req              <= 1'b0;
            half_valid[refill_half] <= 1'b1;
         end else if (pend_v && !refill_req) begin
            refill_req  <= 1'b1;
            refill_half <= pend_half;
            pend_v      <= 1'b0;
         end
         if (adv) begin
            if (half_valid[cur_half]) begin
               rd_ptr <= rd_ptr + ADDR_W'(1);
               if (last_byte) begin
                  half_valid[cur_half] <= 1'b0;
                  if (refill_req || pend_v) begin
                     pend_v    <= 1'b1;
                     pend_half <= cur_half;
                  end else begin
                     refill_req  <= 1'b1;
                     refill_half <= cur_half;
                  end
               end
            end else begin
               underrun <= 1'b1;
            end
         end
      end
   end

   // A status edge that lands on a register write is parked with its masks and applied later.
   assign set_m   = st_pend ? pend_set : status_set_bits;
   assign rst_m   = st_pend ? pend_rst : status_reset_bits;
   assign st_next = ({audio_busy, data_busy, audio_error, audio_status, ctrl_start} | set_m) & ~rst_m;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         addr_out         <= '0;
         track_out        <= '0;
         volume_out       <= '0;
         volume_latch_out <= 1'b0;
         audio_ctrl       <= '0;
         ctrl_start       <= 1'b0;
         audio_start      <= 1'b0;
         data_start       <= 1'b0;
         data_busy        <= 1'b1;
         audio_busy       <= 1'b1;
         audio_error      <= 1'b0;
         audio_status     <= '0;
         st_pend          <= 1'b0;
         pend_set         <= '0;
         pend_rst         <= '0;
      end else begin
         volume_latch_out <= 1'b0;
         if (wr) begin
            if (st_edge) begin
               st_pend  <= 1'b1;
               pend_set <= status_set_bits;
               pend_rst <= status_reset_bits;
            end
            case (reg_addr)
               3'd0: addr_out[7:0]   <= reg_data_in;
               3'd1: addr_out[15:8]  <= reg_data_in;
               3'd2: addr_out[23:16] <= reg_data_in;
               3'd3: begin
                  addr_out[31:24] <= reg_data_in;
                  data_start      <= 1'b1;
                  data_busy       <= 1'b1;
               end
               3'd4: track_out[7:0] <= reg_data_in;
               3'd5: begin
                  track_out[15:8] <= reg_data_in;
                  audio_start     <= 1'b1;
                  audio_busy      <= 1'b1;
               end
               3'd6: begin
                  volume_out       <= reg_data_in;
                  volume_latch_out <= 1'b1;
               end
               3'd7: if (!audio_busy) begin
                  audio_ctrl <= reg_data_in[2:1];
                  ctrl_start <= 1'b1;
               end
            endcase
         end else if (st_edge || st_pend) begin
            st_pend <= 1'b0;
            {audio_busy, data_busy, audio_error, audio_status, ctrl_start} <= st_next;
            if (rst_m[5]) audio_start <= 1'b0;
            if (rst_m[4]) data_start  <= 1'b0;
         end
      end
   end

   assign status_out = {half_valid, audio_start, data_start, underrun, audio_ctrl, ctrl_start};

endmodule

// File: tb/tb_msu_dbuf_regs.sv
// Directed bench for msu_dbuf_regs: transaction-level model plus per-cycle output compare.
module tb_msu_dbuf_regs;

   localparam int ADDR_W = 11;
   localparam int DEPTH  = 2**ADDR_W;
   localparam int HALF   = DEPTH / 2;

   logic              clkin = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic [2:0]        reg_addr = '0;
   logic [7:0]        reg_data_in = '0;
   logic [7:0]        reg_data_out;
   logic              reg_oe_falling = 1'b0, reg_oe_rising = 1'b0, reg_we_rising = 1'b0;
   logic              pgm_we = 1'b0;
   logic [ADDR_W-1:0] pgm_address = '0;
   logic [7:0]        pgm_data = '0;
   logic [31:0]       addr_out;
   logic [15:0]       track_out;
   logic [7:0]        volume_out;
   logic              volume_latch_out;
   logic [7:0]        status_out;
   logic [5:0]        status_set_bits = '0, status_reset_bits = '0;
   logic              status_reset_we = 1'b0;
   logic [ADDR_W-1:0] data_ptr_ext = '0;
   logic              data_ptr_ext_write = 1'b0;
   logic              refill_req, refill_half;
   logic              refill_ack = 1'b0;

   msu_dbuf_regs #(.ADDR_W(ADDR_W), .REV(2'd2)) dut (
      .clkin(clkin), .rst(rst), .enable(enable), .reg_addr(reg_addr),
      .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
      .reg_oe_falling(reg_oe_falling), .reg_oe_rising(reg_oe_rising),
      .reg_we_rising(reg_we_rising), .pgm_we(pgm_we), .pgm_address(pgm_address),
      .pgm_data(pgm_data), .addr_out(addr_out), .track_out(track_out),
      .volume_out(volume_out), .volume_latch_out(volume_latch_out),
      .status_out(status_out), .status_set_bits(status_set_bits),
      .status_reset_bits(status_reset_bits), .status_reset_we(status_reset_we),
      .data_ptr_ext(data_ptr_ext), .data_ptr_ext_write(data_ptr_ext_write),
      .refill_req(refill_req), .refill_half(refill_half), .refill_ack(refill_ack)
   );

   always #5 clkin = ~clkin;

   int n_cmp = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   // Model state, kept as plain values and a request queue.
   logic [7:0]  m_mem [DEPTH];
   int          m_ptr;
   bit   [1:0]  m_hv;
   bit          m_under;
   int          reqq[$];
   bit          m_dbusy, m_abusy, m_aerr, m_cstart, m_astart, m_dstart;
   bit   [1:0]  m_astat, m_actrl;
   logic [31:0] m_addr;
   logic [15:0] m_track;
   logic [7:0]  m_vol, m_rdata;
   logic [7:0]  id_lit [6] = '{8'h53, 8'h2D, 8'h4D, 8'h53, 8'h55, 8'h31};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_status();
      return {m_hv[1], m_hv[0], m_astart, m_dstart, m_under, m_actrl, m_cstart};
   endfunction

   function automatic logic [7:0] exp_reg0();
      return {m_dbusy, m_abusy, m_astat, m_aerr, m_under, 2'd2};
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_hv = 2'b00; m_under = 1'b0; reqq.delete();
      m_dbusy = 1'b1; m_abusy = 1'b1; m_aerr = 1'b0; m_astat = 2'b00;
      m_cstart = 1'b0; m_astart = 1'b0; m_dstart = 1'b0; m_actrl = 2'b00;
      m_addr = '0; m_track = '0; m_vol = '0; m_rdata = '0;
   endtask

   task automatic model_status(input logic [5:0] set, input logic [5:0] clr);
      logic [5:0] v;
      v = ({m_abusy, m_dbusy, m_aerr, m_astat, m_cstart} | set) & ~clr;
      {m_abusy, m_dbusy, m_aerr, m_astat, m_cstart} = v;
      if (clr[5]) m_astart = 1'b0;
      if (clr[4]) m_dstart = 1'b0;
   endtask

   task automatic model_advance();
      int h, nxt;
      h = m_ptr / HALF;
      if (m_hv[h]) begin
         nxt = (m_ptr + 1) % DEPTH;
         if (nxt / HALF != h) begin
            m_hv[h] = 1'b0;
            reqq.push_back(h);
         end
         m_ptr = nxt;
      end else begin
         m_under = 1'b1;
      end
   endtask

   always @(negedge clkin) begin
      if (check_en) begin
         check("status_out", status_out, exp_status());
         check("refill_req", refill_req, reqq.size() != 0);
         if (reqq.size() != 0) check("refill_half", refill_half, reqq[0]);
         check("reg_data_out", reg_data_out, m_rdata);
         check("addr_out", addr_out, m_addr);
         check("track_out", track_out, m_track);
         check("volume_out", volume_out, m_vol);
         check("volume_latch_idle", volume_latch_out, 1'b0);
      end
   end

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic reg_read(input int a);
      check_en = 1'b0;
      reg_addr = 3'(a); enable = 1'b1; reg_oe_falling = 1'b1;
      tick();
      reg_oe_falling = 1'b0;
      if (a == 0) m_rdata = exp_reg0();
      else if (a == 1) m_rdata = m_mem[m_ptr];
      else m_rdata = id_lit[a-2];
      tick();
      reg_oe_rising = 1'b1;
      tick();
      reg_oe_rising = 1'b0; enable = 1'b0;
      if (a == 1) model_advance();
      tick(); tick();
      check_en = 1'b1;
   endtask

   task automatic reg_write(input int a, input logic [7:0] d);
      check_en = 1'b0;
      reg_addr = 3'(a); reg_data_in = d; enable = 1'b1; reg_we_rising = 1'b1;
      tick();
      reg_we_rising = 1'b0; enable = 1'b0;
      case (a)
         0: m_addr[7:0] = d;
         1: m_addr[15:8] = d;
         2: m_addr[23:16] = d;
         3: begin m_addr[31:24] = d; m_dstart = 1'b1; m_dbusy = 1'b1; m_hv = 2'b00; reqq.delete(); end
         4: m_track[7:0] = d;
         5: begin m_track[15:8] = d; m_astart = 1'b1; m_abusy = 1'b1; end
         6: m_vol = d;
         default: if (!m_abusy) begin m_actrl = d[2:1]; m_cstart = 1'b1; end
      endcase
      if (a == 6) begin
         check("volume_latch_pulse", volume_latch_out, 1'b1);
         tick();
         check("volume_latch_end", volume_latch_out, 1'b0);
      end
      tick();
      check_en = 1'b1;
   endtask

   task automatic status_edge(input logic [5:0] set, input logic [5:0] clr);
      check_en = 1'b0;
      status_set_bits = set; status_reset_bits = clr; status_reset_we = 1'b1;
      repeat (3) tick();
      status_reset_we = 1'b0;
      repeat (4) tick();
      status_set_bits = '0; status_reset_bits = '0;
      model_status(set, clr);
      check_en = 1'b1;
   endtask

   task automatic ptr_load(input int p);
      check_en = 1'b0;
      data_ptr_ext = ADDR_W'(p); data_ptr_ext_write = 1'b1;
      repeat (3) tick();
      data_ptr_ext_write = 1'b0;
      repeat (4) tick();
      m_ptr = p; m_hv = 2'b11; reqq.delete(); m_under = 1'b0;
      check_en = 1'b1;
   endtask

   task automatic send_ack();
      check_en = 1'b0;
      refill_ack = 1'b1;
      repeat (3) tick();
      refill_ack = 1'b0;
      repeat (4) tick();
      if (reqq.size() != 0) begin
         m_hv[reqq[0]] = 1'b1;
         void'(reqq.pop_front());
      end
      check_en = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #12;
      check("reset_status", status_out, 8'h00);
      check("reset_refill_req", refill_req, 1'b0);
      check("reset_rdata", reg_data_out, 8'h00);
      @(posedge clkin); #1;
      rst = 1'b0;
      tick();
      check_en = 1'b1;

      // Identification bytes and reset status word.
      for (int a = 2; a < 8; a++) begin
         reg_read(a);
         check("id_reg", reg_data_out, id_lit[a-2]);
      end
      reg_read(0);
      check("reg0_after_reset", reg_data_out, 8'hC2);

      reg_write(0, 8'h44); reg_write(1, 8'h33); reg_write(2, 8'h22);
      reg_write(4, 8'h34); reg_write(5, 8'h12);
      check("track_literal", track_out, 16'h1234);

      // Fill the whole buffer with addr[7:0] and stream through half 0.
      for (int i = 0; i < DEPTH; i++) begin
         pgm_we = 1'b1; pgm_address = ADDR_W'(i); pgm_data = 8'(i);
         m_mem[i] = 8'(i);
         tick();
      end
      pgm_we = 1'b0;
      ptr_load(0);
      for (int i = 0; i < HALF; i++) begin
         reg_read(1);
         if (i < 4) check("seq_data_literal", reg_data_out, 8'(i));
      end
      check("boundary_req", refill_req, 1'b1);
      check("boundary_half", refill_half, 1'b0);
      check("boundary_valid", status_out[7:6], 2'b10);

      // Read through half 1 and wrap: half 0 still unrefilled, so the pointer stalls.
      for (int i = 0; i < HALF; i++) reg_read(1);
      reg_read(1);
      reg_read(0);
      check("underrun_reg0", reg_data_out, 8'hC6);
      send_ack();
      check("queued_req_half", refill_half, 1'b1);
      reg_read(1);
      check("resume_byte0", reg_data_out, 8'h00);
      reg_read(1);
      check("resume_byte1", reg_data_out, 8'h01);

      // Audio control is ignored while audio_busy, accepted once cleared.
      reg_write(7, 8'h03);
      check("ctrl_ignored", status_out[2:0], 3'b000);
      status_edge(6'h00, 6'h20);
      reg_write(7, 8'h03);
      check("ctrl_accepted", status_out[2:0], 3'b011);

      reg_write(6, 8'h80);
      check("volume_literal", volume_out, 8'h80);

      // Status edge landing on a reg 3 write: write first, status one cycle later.
      check_en = 1'b0;
      status_reset_bits = 6'h01; status_reset_we = 1'b1;
      tick(); tick();
      reg_addr = 3'd3; reg_data_in = 8'h12; enable = 1'b1; reg_we_rising = 1'b1;
      tick();
      reg_we_rising = 1'b0; enable = 1'b0;
      check("collide_data_start", status_out[4], 1'b1);
      check("collide_status_held", status_out[0], 1'b1);
      tick();
      check("collide_status_applied", status_out[0], 1'b0);
      check("collide_data_start_kept", status_out[4], 1'b1);
      status_reset_we = 1'b0;
      repeat (4) tick();
      status_reset_bits = '0;
      m_addr[31:24] = 8'h12; m_dstart = 1'b1; m_dbusy = 1'b1; m_hv = 2'b00; reqq.delete();
      model_status(6'h00, 6'h01);
      check_en = 1'b1;
      check("addr_literal", addr_out, 32'h12223344);

      // Asynchronous reset in the middle of a read with a refill pending.
      ptr_load(HALF - 2);
      reg_read(1);
      reg_read(1);
      check("pre_reset_req", refill_req, 1'b1);
      check_en = 1'b0;
      reg_addr = 3'd1; enable = 1'b1; reg_oe_falling = 1'b1;
      tick();
      reg_oe_falling = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_refill_req", refill_req, 1'b0);
      check("async_refill_half", refill_half, 1'b0);
      check("async_status", status_out, 8'h00);
      check("async_rdata", reg_data_out, 8'h00);
      check("async_addr", addr_out, 32'h0);
      check("async_track", track_out, 16'h0);
      check("async_volume", volume_out, 8'h00);
      enable = 1'b0;
      tick(); tick();
      rst = 1'b0;
      model_reset();
      tick();
      check_en = 1'b1;
      reg_read(0);
      check("reg0_after_async", reg_data_out, 8'hC2);
      reg_read(1);
      check("ptr_back_to_zero", reg_data_out, 8'h00);
      tick();

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
